dmem_responder: RTL and testbench

- Data-memory responder for the processor's data port: the target end of the dmem_addr / dmem_wr / write-data / read-data interface.
- Adds an explicit req/ack handshake with a configurable number of wait states, so the core's stage control can stall on memory.
- Holds a word-addressed RAM, one MMIO cycle-counter register, and an out-of-range error flag.
- Sits beside the processor top-level, between the core's data port and the rest of the memory map.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_ram.sv | 41 ++++
 rtl/dmem_responder.sv | 172 +++++++++++++++++
 tb/tb_dmem_responder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the data-memory responder and its RAM.
//   state_e    : responder FSM encoding (IDLE / WAIT / RESP)
//   decode_e   : result of decoding a latched word address
//   *_DEFAULT  : default MMIO counter address and the value returned
//                for loads from addresses nothing answers to
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        DEC_RAM      = 2'd0,
        DEC_MMIO     = 2'd1,
        DEC_UNMAPPED = 2'd2
    } decode_e;

    localparam logic [15:0] CNT_ADDR_DEFAULT = 16'hFFFF;
    localparam logic [31:0] BAD_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram
// Single-port synchronous RAM, 2^DEPTH_LOG2 words of DATA_W bits.
// Ports:
//   clk     : clock, rising edge
//   we_i    : write enable, stores wdata_i at addr_i
//   re_i    : read enable, captures mem[addr_i] into the read register
//   addr_i  : word index
//   wdata_i : write data
//   rdata_o : registered read data, holds until the next enabled read
// Contents are never reset.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
    logic [DATA_W-1:0] rdata_q;

    // The read register only moves on an enabled read, so the responder
    // can use it directly as the held load value for RAM responses.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Target end of the core's data port. Accepts one request at a time with
// a req/ack handshake, inserts WAIT_CYC wait states, then pulses ack for
// one cycle. Serves a word-addressed RAM, a free-running cycle counter at
// CNT_ADDR, and flags any access elsewhere with a sticky error.
// Ports:
//   clk        : clock, rising edge
//   resetn     : asynchronous active-low reset
//   dmem_req   : request, only looked at while idle
//   dmem_addr  : word address
//   dmem_wr    : 1 = store, 0 = load
//   dmem_wdata : store data
//   dmem_rdata : load data, held until the next load response
//   dmem_ack   : one-cycle completion pulse (registered)
//   dmem_err   : sticky unmapped-access flag, cleared only by reset
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 16,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       DEPTH_LOG2 = 10,
    parameter int unsigned       WAIT_CYC   = 1,
    parameter logic [ADDR_W-1:0] CNT_ADDR   = ADDR_W'(CNT_ADDR_DEFAULT),
    parameter logic [DATA_W-1:0] BAD_DATA   = DATA_W'(BAD_DATA_DEFAULT)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              dmem_req,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic              dmem_wr,
    input  logic [DATA_W-1:0] dmem_wdata,
    output logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_ack,
    output logic              dmem_err
);

    localparam int unsigned CNT_W     = 32;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYC);

    state_e              state_q;
    state_e              state_d;
    logic [3:0]          waitCnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                wr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                srcRam_q;
    logic                ack_q;
    logic                err_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                enterResp;
    logic [ADDR_W-1:0]   curAddr;
    logic                curWr;
    logic [DATA_W-1:0]   curWdata;
    decode_e             curDec;
    logic                ramWe;
    logic                ramRe;
    logic [DATA_W-1:0]   ramRdata;

    // Next state, plus the transaction fields that apply at the edge that
    // enters RESP. With zero wait states that edge is the accept edge
    // itself, so the live inputs stand in for the not-yet-latched values.
    always_comb begin
        state_d   = state_q;
        curAddr   = addr_q;
        curWr     = wr_q;
        curWdata  = wdata_q;
        case (state_q)
            IDLE: begin
                curAddr  = dmem_addr;
                curWr    = dmem_wr;
                curWdata = dmem_wdata;
                if (dmem_req) begin
                    state_d = (WAIT_CYC == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (waitCnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        enterResp = (state_d == RESP) && (state_q != RESP);
    end

    // Address decode: low RAM window first, then the counter register.
    always_comb begin
        if ((curAddr >> DEPTH_LOG2) == '0) begin
            curDec = DEC_RAM;
        end else if (curAddr == CNT_ADDR) begin
            curDec = DEC_MMIO;
        end else begin
            curDec = DEC_UNMAPPED;
        end
    end

    // RAM strobes fire only on the edge entering RESP. Gating with resetn
    // keeps a request held high during reset from touching the RAM, which
    // has no reset of its own.
    assign ramWe = resetn && enterResp && curWr  && (curDec == DEC_RAM);
    assign ramRe = resetn && enterResp && !curWr && (curDec == DEC_RAM);

    dmem_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ramWe),
        .re_i    (ramRe),
        .addr_i  (curAddr[DEPTH_LOG2-1:0]),
        .wdata_i (curWdata),
        .rdata_o (ramRdata)
    );

    // All responder state: FSM, request latch, wait and cycle counters,
    // and the registered outputs. srcRam_q remembers whether the last load
    // was answered by the RAM read register or by the local rdata_q.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            waitCnt_q <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            srcRam_q  <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= enterResp;
            cnt_q   <= cnt_q + CNT_W'(1);

            if (state_q == IDLE && dmem_req) begin
                addr_q    <= dmem_addr;
                wr_q      <= dmem_wr;
                wdata_q   <= dmem_wdata;
                waitCnt_q <= WAIT_INIT;
            end else if (state_q == WAIT) begin
                waitCnt_q <= waitCnt_q - 4'd1;
            end

            if (enterResp) begin
                if (curDec == DEC_UNMAPPED) begin
                    err_q <= 1'b1;
                end
                if (curWr) begin
                    // Clearing wins over the free-running increment above.
                    if (curDec == DEC_MMIO) begin
                        cnt_q <= '0;
                    end
                end else begin
                    srcRam_q <= (curDec == DEC_RAM);
                    if (curDec == DEC_MMIO) begin
                        rdata_q <= DATA_W'(cnt_q);
                    end else if (curDec == DEC_UNMAPPED) begin
                        rdata_q <= BAD_DATA;
                    end
                end
            end
        end
    end

    assign dmem_rdata = srcRam_q ? ramRdata : rdata_q;
    assign dmem_ack   = ack_q;
    assign dmem_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Two responders share clock and reset: dutA with one wait state and dutB
// with none. Each task drives one scenario; expected load data is queued
// when a request is issued and popped when its ack arrives.
module tb_dmem_responder;

    localparam int          WAIT_A = 1;
    localparam int          WAIT_B = 0;
    localparam logic [31:0] BAD    = 32'hDEADBEEF;

    logic        clk    = 1'b0;
    logic        resetn = 1'b1;

    logic        reqA   = 1'b0;
    logic        wrA    = 1'b0;
    logic [15:0] addrA  = '0;
    logic [31:0] wdataA = '0;
    logic [31:0] rdataA;
    logic        ackA;
    logic        errA;

    logic        reqB   = 1'b0;
    logic        wrB    = 1'b0;
    logic [15:0] addrB  = '0;
    logic [31:0] wdataB = '0;
    logic [31:0] rdataB;
    logic        ackB;
    logic        errB;

    int          errors    = 0;
    int          checks    = 0;
    int          edgeNum   = 0;
    int          ackCountA = 0;
    logic [31:0] expQ [$];
    logic [31:0] lastLoadA = '0;
    logic [31:0] memModel [int];

    dmem_responder #(
        .ADDR_W(16), .DATA_W(32), .DEPTH_LOG2(10), .WAIT_CYC(WAIT_A),
        .CNT_ADDR(16'hFFFF), .BAD_DATA(32'hDEADBEEF)
    ) dutA (
        .clk(clk), .resetn(resetn), .dmem_req(reqA), .dmem_addr(addrA),
        .dmem_wr(wrA), .dmem_wdata(wdataA), .dmem_rdata(rdataA),
        .dmem_ack(ackA), .dmem_err(errA)
    );

    dmem_responder #(
        .ADDR_W(16), .DATA_W(32), .DEPTH_LOG2(10), .WAIT_CYC(WAIT_B),
        .CNT_ADDR(16'hFFFF), .BAD_DATA(32'hDEADBEEF)
    ) dutB (
        .clk(clk), .resetn(resetn), .dmem_req(reqB), .dmem_addr(addrB),
        .dmem_wr(wrB), .dmem_wdata(wdataB), .dmem_rdata(rdataB),
        .dmem_ack(ackB), .dmem_err(errB)
    );

    always #5 clk = ~clk;

    // Edge counter used to predict counter values from accept edges.
    always @(posedge clk) edgeNum <= edgeNum + 1;

    // Counts every ack pulse from dutA, sampled mid-cycle.
    always @(negedge clk) if (ackA === 1'b1) ackCountA <= ackCountA + 1;

    // Issues one transaction from a negedge with the FSM idle. Reports how
    // many edges after the accept edge the ack became visible, the data and
    // error flag seen with the ack, and the accept edge number. Returns at
    // the negedge after the ack, when the FSM is idle again.
    task automatic doTxn(input bit useB, input logic [15:0] addr, input logic wr,
                         input logic [31:0] wdata, output int edgesToAck,
                         output logic [31:0] rdataSeen, output logic errSeen,
                         output int acceptEdge);
        if (useB) begin
            reqB = 1'b1; addrB = addr; wrB = wr; wdataB = wdata;
        end else begin
            reqA = 1'b1; addrA = addr; wrA = wr; wdataA = wdata;
        end
        @(negedge clk);
        acceptEdge = edgeNum;
        if (useB) reqB = 1'b0; else reqA = 1'b0;
        edgesToAck = 0;
        while (edgesToAck < 20 && (useB ? ackB : ackA) !== 1'b1) begin
            @(negedge clk);
            edgesToAck++;
        end
        rdataSeen = useB ? rdataB : rdataA;
        errSeen   = useB ? errB : errA;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ackA !== 1'b0) begin errors++; $display("[TB] FAIL reset_ackA: got %b want 0", ackA); end
        checks++; if (rdataA !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdataA: got %h want 0", rdataA); end
        checks++; if (errA !== 1'b0) begin errors++; $display("[TB] FAIL reset_errA: got %b want 0", errA); end
        checks++; if (ackB !== 1'b0) begin errors++; $display("[TB] FAIL reset_ackB: got %b want 0", ackB); end
        checks++; if (rdataB !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdataB: got %h want 0", rdataB); end
        checks++; if (errB !== 1'b0) begin errors++; $display("[TB] FAIL reset_errB: got %b want 0", errB); end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        logic [15:0] tAddr [8] = '{16'd5, 16'd5, 16'h03FF, 16'h03FF, 16'd0, 16'd10, 16'd7, 16'd0};
        bit          tWr   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] tData [8] = '{32'h12345678, 32'h0, 32'h0BADF00D, 32'h0, 32'hCAFE0001,
                                   32'h00001010, 32'h00000077, 32'h0};
        logic [31:0] exp;
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          acc;
        for (int i = 0; i < 8; i++) begin
            if (tWr[i]) begin
                memModel[int'(tAddr[i])] = tData[i];
                exp = lastLoadA;
            end else begin
                exp = memModel[int'(tAddr[i])];
                lastLoadA = exp;
            end
            expQ.push_back(exp);
            doTxn(1'b0, tAddr[i], tWr[i], tData[i], lat, rd, er, acc);
            exp = expQ.pop_front();
            checks++; if (lat !== WAIT_A) begin errors++; $display("[TB] FAIL sl_latency[%0d]: got %0d want %0d", i, lat, WAIT_A); end
            checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL sl_rdata[%0d]: got %h want %h", i, rd, exp); end
            checks++; if (er !== 1'b0) begin errors++; $display("[TB] FAIL sl_err[%0d]: got %b want 0", i, er); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [31:0] exp;
        logic        er;
        int          lat;
        int          acc;
        int          ackIdx [$];
        int          first;
        int          gap;
        expQ.delete();
        doTxn(1'b1, 16'd1, 1'b1, 32'hB1B10001, lat, rd, er, acc);
        checks++; if (lat !== WAIT_B) begin errors++; $display("[TB] FAIL b2b_store1_latency: got %0d want %0d", lat, WAIT_B); end
        doTxn(1'b1, 16'd2, 1'b1, 32'hB2B20002, lat, rd, er, acc);
        checks++; if (lat !== WAIT_B) begin errors++; $display("[TB] FAIL b2b_store2_latency: got %0d want %0d", lat, WAIT_B); end
        expQ.push_back(32'hB1B10001);
        expQ.push_back(32'hB2B20002);
        reqB = 1'b1; addrB = 16'd1; wrB = 1'b0; wdataB = '0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (ackB === 1'b1) begin
                ackIdx.push_back(n);
                if (expQ.size() > 0) begin
                    exp = expQ.pop_front();
                    checks++; if (rdataB !== exp) begin errors++; $display("[TB] FAIL b2b_rdata[%0d]: got %h want %h", ackIdx.size(), rdataB, exp); end
                end
                if (ackIdx.size() == 1) addrB = 16'd2;
                else reqB = 1'b0;
            end
        end
        reqB  = 1'b0;
        first = (ackIdx.size() >= 1) ? ackIdx[0] : -1;
        gap   = (ackIdx.size() >= 2) ? ackIdx[1] - ackIdx[0] : -1;
        checks++; if (ackIdx.size() !== 2) begin errors++; $display("[TB] FAIL b2b_ack_count: got %0d want 2", ackIdx.size()); end
        checks++; if (first !== 0) begin errors++; $display("[TB] FAIL b2b_first_ack: got %0d want 0", first); end
        checks++; if (gap !== 2) begin errors++; $display("[TB] FAIL b2b_ack_spacing: got %0d want 2", gap); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_unmapped();
        logic [15:0] tAddr [4] = '{16'h0800, 16'h0800, 16'h0000, 16'h0400};
        bit          tWr   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] exp;
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          acc;
        for (int i = 0; i < 4; i++) begin
            if (tWr[i]) exp = lastLoadA;
            else begin
                exp = (tAddr[i] < 16'h0400) ? memModel[int'(tAddr[i])] : BAD;
                lastLoadA = exp;
            end
            expQ.push_back(exp);
            doTxn(1'b0, tAddr[i], tWr[i], 32'h55555555, lat, rd, er, acc);
            exp = expQ.pop_front();
            checks++; if (lat !== WAIT_A) begin errors++; $display("[TB] FAIL um_latency[%0d]: got %0d want %0d", i, lat, WAIT_A); end
            checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL um_rdata[%0d]: got %h want %h", i, rd, exp); end
            checks++; if (er !== 1'b1) begin errors++; $display("[TB] FAIL um_err[%0d]: got %b want 1", i, er); end
        end
    endtask

    task automatic test_counter();
        logic [31:0] exp;
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          accStore;
        int          acc;
        expQ.push_back(lastLoadA);
        doTxn(1'b0, 16'hFFFF, 1'b1, 32'h0000ABCD, lat, rd, er, accStore);
        exp = expQ.pop_front();
        checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL cnt_store_rdata: got %h want %h", rd, exp); end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            // Cleared at accStore+WAIT_A; read at (edgeNum+1)+WAIT_A, taking
            // the value held just before that edge.
            exp = 32'(edgeNum - accStore);
            lastLoadA = exp;
            expQ.push_back(exp);
            doTxn(1'b0, 16'hFFFF, 1'b0, 32'h0, lat, rd, er, acc);
            exp = expQ.pop_front();
            checks++; if (lat !== WAIT_A) begin errors++; $display("[TB] FAIL cnt_latency[%0d]: got %0d want %0d", i, lat, WAIT_A); end
            checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL cnt_value[%0d]: got %0d want %0d", i, rd, exp); end
            checks++; if (er !== 1'b1) begin errors++; $display("[TB] FAIL cnt_err_sticky[%0d]: got %b want 1", i, er); end
        end
    endtask

    task automatic test_ignore_changes();
        logic [31:0] exp;
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          acc;
        int          base;
        base = ackCountA;
        reqA = 1'b1; addrA = 16'd9; wrA = 1'b1; wdataA = 32'h99999999;
        @(negedge clk);
        addrA = 16'd10; wdataA = 32'h00000001; wrA = 1'b0; reqA = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        memModel[9] = 32'h99999999;
        checks++; if (ackCountA - base !== 1) begin errors++; $display("[TB] FAIL ign_ack_count: got %0d want 1", ackCountA - base); end
        checks++; if (rdataA !== lastLoadA) begin errors++; $display("[TB] FAIL ign_rdata_held: got %h want %h", rdataA, lastLoadA); end
        for (int i = 9; i <= 10; i++) begin
            exp = memModel[i];
            lastLoadA = exp;
            expQ.push_back(exp);
            doTxn(1'b0, 16'(i), 1'b0, 32'h0, lat, rd, er, acc);
            exp = expQ.pop_front();
            checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL ign_readback[%0d]: got %h want %h", i, rd, exp); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          acc;
        int          base;
        expQ.push_back(memModel[7]);
        doTxn(1'b0, 16'd7, 1'b0, 32'h0, lat, rd, er, acc);
        exp = expQ.pop_front();
        lastLoadA = exp;
        checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL rst_pre_load: got %h want %h", rd, exp); end
        base = ackCountA;
        reqA = 1'b1; addrA = 16'd7; wrA = 1'b1; wdataA = 32'hBAD0BAD0;
        @(negedge clk);
        resetn = 1'b0; reqA = 1'b0;
        #1;
        checks++; if (ackA !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_ack: got %b want 0", ackA); end
        checks++; if (rdataA !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_rdata: got %h want 0", rdataA); end
        checks++; if (errA !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_err: got %b want 0", errA); end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        lastLoadA = '0;
        expQ.push_back(memModel[7]);
        doTxn(1'b0, 16'd7, 1'b0, 32'h0, lat, rd, er, acc);
        exp = expQ.pop_front();
        #1;
        checks++; if (lat !== WAIT_A) begin errors++; $display("[TB] FAIL rst_post_latency: got %0d want %0d", lat, WAIT_A); end
        checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL rst_post_rdata: got %h want %h", rd, exp); end
        checks++; if (er !== 1'b0) begin errors++; $display("[TB] FAIL rst_post_err: got %b want 0", er); end
        checks++; if (ackCountA - base !== 1) begin errors++; $display("[TB] FAIL rst_ack_count: got %0d want 1", ackCountA - base); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        test_unmapped();
        test_counter();
        test_ignore_changes();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
